// File: rtl/cgra_kernel_scheduler.sv
// cgra_kernel_scheduler: round-robin launcher that shares one CGRA among N_REQ requesters,
// with completion/timeout/abort reporting back to the owning requester.
module cgra_kernel_scheduler #(
  parameter int N_REQ = 4,
  parameter int KID_W = 4,
  parameter int TIMEOUT_W = 16,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*KID_W-1:0] req_kid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  output logic                   cgra_start_o,
  output logic [KID_W-1:0]       cgra_kid_o,
  input  logic                   cgra_busy_i,
  input  logic                   cgra_done_i,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       err_o,
  output logic                   busy_o,
  output logic [OW-1:0]          owner_o
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RECOVER = 2'd3;
  logic [1:0] state;
  logic [OW-1:0] rr_ptr, winner, idx;
  logic found;
  logic [TIMEOUT_W-1:0] timer;
  always_comb begin
    winner = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = OW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  assign req_ready_o = (rst_ni && enable_i && found && state == IDLE) ? N_REQ'(1) << winner : '0;
  assign cgra_start_o = state == LAUNCH && enable_i;
  assign busy_o = state != IDLE;
  // timer==0 after load means the watchdog is disabled for this job
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner_o <= '0;
      cgra_kid_o <= '0;
      timer <= '0;
      done_o <= '0;
      err_o <= '0;
    end else begin
      done_o <= '0;
      err_o <= '0;
      if (state == IDLE) begin
        if (enable_i && found) begin
          owner_o <= winner;
          cgra_kid_o <= req_kid_i[winner*KID_W +: KID_W];
          rr_ptr <= (winner == OW'(N_REQ-1)) ? '0 : winner + 1'b1;
          state <= LAUNCH;
        end
      end else if (state == WAIT && cgra_done_i) begin
        done_o[owner_o] <= 1'b1;
        state <= IDLE;
      end else if (!enable_i) begin
        err_o[owner_o] <= 1'b1;
        state <= IDLE;
      end else if (state == LAUNCH) begin
        timer <= timeout_i;
        state <= WAIT;
      end else if (state == WAIT) begin
        if (timer == TIMEOUT_W'(1)) begin
          err_o[owner_o] <= 1'b1;
          state <= RECOVER;
        end
        if (timer != '0) timer <= timer - 1'b1;
      end else if (!cgra_busy_i) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_cgra_kernel_scheduler.sv
// tb_cgra_kernel_scheduler: directed bench with a scoreboard of expected done/err pulses.
module tb_cgra_kernel_scheduler;
  localparam int N = 4, K = 4, T = 16;
  logic clk = 1'b0, rst_ni, enable, busy_in, done_in;
  logic [N-1:0] valid, ready, done_o, err_o;
  logic [N*K-1:0] kid;
  logic [T-1:0] timeout;
  logic start, busy;
  logic [K-1:0] kid_o;
  logic [1:0] owner;
  int total = 0, passed = 0;
  logic [7:0] sb[$];
  always #5 clk = ~clk;
  cgra_kernel_scheduler #(.N_REQ(N), .KID_W(K), .TIMEOUT_W(T)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .req_valid_i(valid), .req_kid_i(kid),
    .req_ready_o(ready), .timeout_i(timeout), .cgra_start_o(start), .cgra_kid_o(kid_o),
    .cgra_busy_i(busy_in), .cgra_done_i(done_in), .done_o(done_o), .err_o(err_o),
    .busy_o(busy), .owner_o(owner)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // every done/err pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_ni && (done_o != '0 || err_o != '0)) begin
      if (sb.size() == 0) chk("unexpected_pulse", {24'd0, done_o, err_o}, 32'd0);
      else chk("sb_pulse", {24'd0, done_o, err_o}, {24'd0, sb.pop_front()});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end
  initial begin
    rst_ni = 0; enable = 1; valid = 0; kid = 0; timeout = 0; busy_in = 0; done_in = 0;
    tick();
    chk("rst_busy", busy, 0); chk("rst_owner", owner, 0); chk("rst_kid", kid_o, 0);
    chk("rst_done", done_o, 0); chk("rst_err", err_o, 0); chk("rst_start", start, 0);
    chk("rst_ready", ready, 0);
    rst_ni = 1;
    // single job
    valid = 4'b0001; kid[3:0] = 4'd5; #1;
    chk("t1_ready", ready, 4'b0001);
    tick(); valid = 0;
    chk("t1_start", start, 1); chk("t1_kid", kid_o, 5); chk("t1_busy", busy, 1);
    sb.push_back({4'b0001, 4'b0000});
    tick();
    chk("t1_start_once", start, 0);
    repeat (9) tick();
    chk("t1_kid_hold", kid_o, 5);
    done_in = 1; tick(); done_in = 0;
    chk("t1_done", done_o, 4'b0001); chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_once", done_o, 0);
    // fairness from a fresh pointer
    rst_ni = 0; tick(); rst_ni = 1;
    kid = {4'd11, 4'd10, 4'd9, 4'd8};
    valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("t2_ready%0d", j), ready, 32'd1 << (j % 4));
      tick();
      chk($sformatf("t2_owner%0d", j), owner, j % 4);
      chk($sformatf("t2_kid%0d", j), kid_o, 8 + (j % 4));
      chk($sformatf("t2_start%0d", j), start, 1);
      sb.push_back({4'(1 << (j % 4)), 4'b0000});
      tick(); done_in = 1; tick(); done_in = 0;
      chk($sformatf("t2_done%0d", j), done_o, 32'd1 << (j % 4));
    end
    valid = 0;
    // timeout with CGRA still busy, pointer now at 1 so requester 0 still wins alone
    timeout = 8; valid = 4'b0001; #1;
    chk("t3_ready", ready, 4'b0001);
    tick(); valid = 0; busy_in = 1;
    sb.push_back({4'b0000, 4'b0001});
    repeat (8) tick();
    chk("t3_no_early_err", err_o, 0); chk("t3_busy_wait", busy, 1);
    tick();
    chk("t3_err", err_o, 4'b0001);
    valid = 4'b0001; #1;
    chk("t3_no_ready_recover", ready, 0);
    valid = 0;
    tick(); done_in = 1; tick(); done_in = 0;
    chk("t3_late_done_absorbed", done_o, 0);
    repeat (3) tick();
    chk("t3_recover_hold", busy, 1);
    busy_in = 0; tick();
    chk("t3_idle", busy, 0);
    // done on the expiry cycle wins
    timeout = 4; valid = 4'b0001; #1;
    tick(); valid = 0;
    sb.push_back({4'b0001, 4'b0000});
    repeat (4) tick();
    done_in = 1; tick(); done_in = 0;
    chk("t4_done", done_o, 4'b0001); chk("t4_no_err", err_o, 0); chk("t4_idle", busy, 0);
    tick();
    chk("t4_no_late_err", err_o, 0);
    // abort by enable drop during WAIT
    timeout = 0; valid = 4'b0100; #1;
    chk("t5_ready", ready, 4'b0100);
    tick(); valid = 0;
    chk("t5_owner", owner, 2);
    sb.push_back({4'b0000, 4'b0100});
    tick(); tick();
    enable = 0; valid = 4'b1111; #1;
    tick();
    chk("t5_err", err_o, 4'b0100); chk("t5_idle", busy, 0); chk("t5_no_ready", ready, 0);
    tick();
    chk("t5_err_once", err_o, 0); chk("t5_no_ready2", ready, 0);
    enable = 1; valid = 0;
    // reset mid-WAIT clears the pointer
    valid = 4'b1000; #1;
    chk("t6_ready", ready, 4'b1000);
    tick(); valid = 0; tick(); tick();
    rst_ni = 0; tick();
    chk("t6_busy", busy, 0); chk("t6_owner", owner, 0); chk("t6_kid", kid_o, 0);
    chk("t6_done", done_o, 0); chk("t6_err", err_o, 0); chk("t6_start", start, 0);
    rst_ni = 1; valid = 4'b1010; #1;
    chk("t6_ready_after", ready, 4'b0010);
    tick(); valid = 0;
    chk("t6_owner_after", owner, 1);
    sb.push_back({4'b0010, 4'b0000});
    tick(); done_in = 1; tick(); done_in = 0;
    chk("t6_done_after", done_o, 4'b0010);
    // spurious done in IDLE
    done_in = 1; tick(); done_in = 0;
    chk("spurious_busy", busy, 0);
    tick();
    chk("spurious_done", done_o, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
